// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM state encoding.
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/alu_div_step.sv
// One combinational non-restoring division step on the {P,A} pair against divisor magnitude B.
module alu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] b_ext;

  always_comb begin
    p_shift = {p[WIDTH-1:0], a[WIDTH-1]};
    b_ext   = {1'b0, b};
    // The sign of P survives the shift because |P| never exceeds B, so either sign may steer the step.
    if (p[WIDTH]) begin
      p_next = p_shift + b_ext;
    end else begin
      p_next = p_shift - b_ext;
    end
    a_next = {a[WIDTH-2:0], ~p_next[WIDTH]};
  end

endmodule

// File: rtl/alu_div.sv
// Sequential signed divider: one non-restoring step per cycle on operand magnitudes, then a sign fix-up.
// Result packs {remainder, quotient}; outputs hold until the next accepted start.
module alu_div
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t state;
  div_state_t next_state;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH:0]   p_fix;
  logic             accept;
  logic             div_zero;

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .b      (b_reg),
    .p_next (p_next),
    .a_next (a_next)
  );

  assign accept   = (state == ST_IDLE) && start;
  assign div_zero = (divisor == '0);
  assign p_fix    = p_reg[WIDTH] ? (p_reg + {1'b0, b_reg}) : p_reg;
  assign result   = {remainder, quotient};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = div_zero ? ST_DONE : ST_DIV;
      ST_DIV:  if (count == LAST_STEP) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_DIV) || (state == ST_FIX);
    done = (state == ST_DONE);
  end

  // Working registers and visible outputs are kept apart so outputs only move at FIX or a zero-divisor accept.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count     <= '0;
      p_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg <= dividend[WIDTH-1] ? -dividend : dividend;
            b_reg <= divisor[WIDTH-1] ? -divisor : divisor;
            r_neg <= dividend[WIDTH-1];
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            p_reg <= '0;
            count <= '0;
            if (div_zero) begin
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        ST_DIV: begin
          p_reg <= p_next;
          a_reg <= a_next;
          count <= count + CW'(1);
        end
        ST_FIX: begin
          p_reg     <= p_fix;
          dbz       <= 1'b0;
          quotient  <= q_neg ? -a_reg : a_reg;
          remainder <= r_neg ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed vector table, random operands against an arithmetic model,
// and hand-written sequences for ignored starts and mid-operation clear.
module tb_alu_div;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic [2*W-1:0] result;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  alu_div #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder),
    .result    (result)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: signed division truncating toward zero, remainder takes the dividend's sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      z = 1'b1;
      q = '1;
      r = a;
    end else begin
      z = 1'b0;
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Start is accepted on the next rising edge; operands are scrambled afterwards.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Cycle 1 is the cycle right after the accepting edge; 100 means done never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (done) break;
    end
    if (!done) cyc = 100;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           cyc;
    model(a, b, eq, er, ez);
    launch(a, b);
    wait_done(cyc);
    check({name, ".latency"}, 64'(cyc), ez ? 64'd1 : 64'd34);
    check({name, ".quotient"}, 64'(quotient), 64'(eq));
    check({name, ".remainder"}, 64'(remainder), 64'(er));
    check({name, ".dbz"}, 64'(dbz), 64'(ez));
    check({name, ".result"}, result, {er, eq});
    @(negedge clock);
    check({name, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc;
    int   bad_busy;
    logic [2*W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'h0000000E, r: 32'h00000002, z: 1'b0, lat: 34};
    vecs[1] = '{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2, r: 32'hFFFFFFFE, z: 1'b0, lat: 34};
    vecs[2] = '{a: 32'd100,        b: 32'hFFFFFFF9,   q: 32'hFFFFFFF2, r: 32'h00000002, z: 1'b0, lat: 34};
    vecs[3] = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000, r: 32'h00000000, z: 1'b0, lat: 34};
    vecs[4] = '{a: 32'd7,          b: 32'd100,        q: 32'h00000000, r: 32'h00000007, z: 1'b0, lat: 34};
    vecs[5] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFFFFFF, r: 32'h00000005, z: 1'b1, lat: 1};

    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dbz", 64'(dbz), 64'd0);
    check("reset.result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(cyc);
      check($sformatf("vec%0d.latency", i), 64'(cyc), 64'(vecs[i].lat));
      check($sformatf("vec%0d.quotient", i), 64'(quotient), 64'(vecs[i].q));
      check($sformatf("vec%0d.remainder", i), 64'(remainder), 64'(vecs[i].r));
      check($sformatf("vec%0d.dbz", i), 64'(dbz), 64'(vecs[i].z));
      check($sformatf("vec%0d.result", i), result, {vecs[i].r, vecs[i].q});
    end

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 1) ? W'($urandom_range(1, 20)) : -W'($urandom_range(1, 20));
        2: rb = '0;
        default: begin
          rb = $urandom;
          ra = W'($urandom_range(0, 50));
        end
      endcase
      run_op($sformatf("rand%0d", i), ra, rb);
    end

    // Start while busy is ignored; outputs hold the previous result during the run.
    run_op("pre_ignore", 32'd20, 32'd3);
    held = result;
    launch(32'd100, 32'd7);
    bad_busy = 0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (cyc == 5) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!busy) bad_busy++;
      if (cyc == 20) check("ignore.hold_during_div", result, held);
    end
    check("ignore.latency", 64'(cyc), 64'd34);
    check("ignore.busy_gaps", 64'(bad_busy), 64'd0);
    check("ignore.quotient", 64'(quotient), 64'd14);
    check("ignore.remainder", 64'(remainder), 64'd2);

    // Start presented during DONE is dropped, not queued.
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clock);
    start = 1'b0;
    check("done_start.busy", 64'(busy), 64'd0);
    @(negedge clock);
    check("done_start.busy_later", 64'(busy), 64'd0);
    check("done_start.quotient", 64'(quotient), 64'd14);

    // Asynchronous clear in the middle of a division.
    launch(32'd100, 32'd7);
    for (int c = 0; c < 10; c++) @(negedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("clear.busy", 64'(busy), 64'd0);
    check("clear.done", 64'(done), 64'd0);
    check("clear.dbz", 64'(dbz), 64'd0);
    check("clear.result", result, 64'd0);
    #1;
    clear = 1'b0;
    run_op("after_clear", 32'd9, 32'd3);
    check("after_clear.quotient_3", 64'(quotient), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
